wino_btdb_tile_sched: RTL
=========================

WINO_BTDB_TILE_SCHED -- requirements
Module: wino_btdb_tile_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 18, element width in bits.
REQ-002 SHALL have parameter NUM_TILES, 16, tiles per frame (at least 1).
REQ-003 SHALL have port clk  in  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  in  1  input element valid.
REQ-006 SHALL have port in_ready  out  1  input element accepted when in_valid and in_ready are both 1.
REQ-007 SHALL have port in_data  in  DATA_WIDTH  tile element, row-major d0..d8.
REQ-008 SHALL have port out_valid  out  1  transformed tile valid.
REQ-009 SHALL have port out_ready  in  1  downstream accept.
REQ-010 SHALL have port out_data  out  9*DATA_WIDTH  o0..o8, with o0 in the LSBs.
REQ-011 SHALL have port out_tile_idx  out  $clog2(NUM_TILES) (minimum 1)  tile index within the frame.
REQ-012 SHALL have port out_last  out  1  high with out_valid when out_tile_idx equals NUM_TILES-1.
REQ-013 SHALL have port frame_done  out  1  one-cycle pulse on the output handshake of the last tile.

Function
REQ-014 SHALL gather 9 accepted elements into one tile using a 0..8 element counter that returns to 0 after element 8.
REQ-015 SHALL use two tile banks (ping-pong): a write pointer selects the bank being filled, and that bank's full flag is set on the edge that accepts element 8.
REQ-016 SHALL set in_ready = NOT full[wr_ptr], derived combinationally from registered state only.
REQ-017 SHALL toggle wr_ptr on the acceptance of element 8.
REQ-018 SHALL load the output register from bank rd_ptr when full[rd_ptr] is set and the output register is empty or handshaking in the same cycle; on that load it clears full[rd_ptr] and toggles rd_ptr.
REQ-019 SHALL assert out_valid exactly one edge after the edge that accepted element 8, provided the output register is free.
REQ-020 SHALL hold out_data, out_tile_idx and out_last stable while out_valid is high and out_ready is low.
REQ-021 SHALL compute the row stage as: r0=d0+d3, r1=d1+d4, r2=d2+d5; r3=d3-d0, r4=d4-d1, r5=d5-d2; r6=d6-d0, r7=d7-d1, r8=d8-d2.
REQ-022 SHALL compute the column stage per row triple (a,b,c) as (a+b, b-a, c-a), giving o0..o8.
REQ-023 SHALL treat data as two's complement and, by default, wrap results modulo 2^DATA_WIDTH.
REQ-024 SHALL sustain one element per cycle with zero bubbles while out_ready is held at 1.
REQ-025 SHALL allow simultaneous element-8 acceptance and output load in the same cycle without loss, and SHALL handle a simultaneous set/clear of a full flag correctly.
REQ-026 SHALL, with both banks and the output register occupied, hold in_ready at 0 until an output handshake occurs.
REQ-027 SHALL increment the tile index counter on each output handshake and wrap it from NUM_TILES-1 to 0.

Reset
REQ-028 SHALL, while rst_n is 0, force: element counter, wr_ptr, rd_ptr, full flags and tile index to 0; out_valid=0; out_data=0; out_last=0; frame_done=0.
REQ-029 SHALL discard any partial tile on reset; in_ready is 1 from the first cycle after release.

Configuration
REQ-030 SHALL, with WINO_BTDB_SAT_EN defined, compute at DATA_WIDTH+2 bits and clamp each oN to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-031 SHALL, with WINO_BTDB_SAT_EN defined, add output port sat_hit (1 bit), which pulses with an output load when any oN clamped.
REQ-032 SHALL, without WINO_BTDB_SAT_EN, omit sat_hit and use wrap arithmetic per REQ-023.

Structure
REQ-033 SHALL place TILE_ELEMS=9, the default DATA_WIDTH, and typedef tile_t (9 x DATA_WIDTH) in package wino_sched_pkg.
REQ-034 SHALL implement REQ-021/REQ-022 (and the REQ-030 clamping) in one combinational sub-module, wino_btdb_core.

Verification
REQ-035 SHALL cover: tile d=1..9, out_ready=1 -> o = 12,2,4,6,0,0,12,0,0, with out_valid one edge after element 8.
REQ-036 SHALL cover: out_ready=0, continuous input -> exactly 27 elements accepted, then in_ready=0; a single out_ready pulse re-opens exactly 9 slots.
REQ-037 SHALL cover: NUM_TILES=4, 5 tiles -> out_last and frame_done on tile 3; the fifth tile has out_tile_idx=0.
REQ-038 SHALL cover: DATA_WIDTH=18, d3=d4=131071, others 0 -> o0=-2 without macro; o0=131071 and sat_hit=1 with WINO_BTDB_SAT_EN.
REQ-039 SHALL cover: rst_n low after 5 elements, then a full tile 1..9 -> output equals REQ-035 with out_tile_idx=0.
REQ-040 SHALL cover: random in_valid/out_ready for 1000 tiles -> outputs match a reference model, in order, with no loss or duplication.

Source files
------------

// File: rtl/wino_sched_pkg.sv
// Shared constants and types for the Winograd B^T d B tile scheduler.
// Tile geometry, default element width and the tile-index width helper.
package wino_sched_pkg;

    localparam int TILE_ELEMS     = 9;
    localparam int DEF_DATA_WIDTH = 18;

    typedef logic [TILE_ELEMS-1:0][DEF_DATA_WIDTH-1:0] tile_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wino_btdb_core.sv
// Combinational 3x3 Winograd input transform: row stage, then column stage.
// WINO_BTDB_SAT_EN widens the datapath by two bits and clamps each result.
module wino_btdb_core
    import wino_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [TILE_ELEMS*DATA_WIDTH-1:0] tile_in,
    output logic [TILE_ELEMS*DATA_WIDTH-1:0] tile_out
`ifdef WINO_BTDB_SAT_EN
    ,
    output logic                             sat_hit
`endif
);

`ifdef WINO_BTDB_SAT_EN
    localparam int CW = DATA_WIDTH + 2;
`else
    localparam int CW = DATA_WIDTH;
`endif

    logic signed [CW-1:0] d [TILE_ELEMS];
    logic signed [CW-1:0] r [TILE_ELEMS];
    logic signed [CW-1:0] o [TILE_ELEMS];

    always_comb begin
        for (int i = 0; i < TILE_ELEMS; i++) begin
            d[i] = CW'($signed(tile_in[i*DATA_WIDTH +: DATA_WIDTH]));
        end
        for (int k = 0; k < 3; k++) begin
            r[k]   = d[k] + d[k+3];
            r[k+3] = d[k+3] - d[k];
            r[k+6] = d[k+6] - d[k];
        end
        // each row triple (a,b,c) becomes (a+b, b-a, c-a)
        for (int k = 0; k < 3; k++) begin
            o[3*k]   = r[3*k] + r[3*k+1];
            o[3*k+1] = r[3*k+1] - r[3*k];
            o[3*k+2] = r[3*k+2] - r[3*k];
        end
    end

`ifdef WINO_BTDB_SAT_EN
    localparam logic signed [CW-1:0] MAXV = {3'b000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [CW-1:0] MINV = {3'b111, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        sat_hit  = 1'b0;
        tile_out = '0;
        for (int i = 0; i < TILE_ELEMS; i++) begin
            if (o[i] > MAXV) begin
                tile_out[i*DATA_WIDTH +: DATA_WIDTH] = MAXV[DATA_WIDTH-1:0];
                sat_hit = 1'b1;
            end else if (o[i] < MINV) begin
                tile_out[i*DATA_WIDTH +: DATA_WIDTH] = MINV[DATA_WIDTH-1:0];
                sat_hit = 1'b1;
            end else begin
                tile_out[i*DATA_WIDTH +: DATA_WIDTH] = o[i][DATA_WIDTH-1:0];
            end
        end
    end
`else
    always_comb begin
        tile_out = '0;
        for (int i = 0; i < TILE_ELEMS; i++) begin
            tile_out[i*DATA_WIDTH +: DATA_WIDTH] = o[i];
        end
    end
`endif

endmodule

// File: rtl/wino_btdb_tile_sched.sv
// Gathers 3x3 tiles into ping-pong banks and emits their transform with a frame index.
// Define WINO_BTDB_SAT_EN for saturating arithmetic and the sat_hit output.
module wino_btdb_tile_sched
    import wino_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_TILES  = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH-1:0]              in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [TILE_ELEMS*DATA_WIDTH-1:0]   out_data,
    output logic [idx_width(NUM_TILES)-1:0]    out_tile_idx,
    output logic                               out_last,
    output logic                               frame_done
`ifdef WINO_BTDB_SAT_EN
    ,
    output logic                               sat_hit
`endif
);

    localparam int TW = TILE_ELEMS * DATA_WIDTH;
    localparam int IW = idx_width(NUM_TILES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_TILES - 1);

    logic [3:0]         cnt_q, cnt_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         full_q, full_d;
    logic [1:0][TW-1:0] bank_q, bank_d;
    logic               out_valid_q, out_valid_d;
    logic [TW-1:0]      out_data_q, out_data_d;
    logic [IW-1:0]      tile_idx_q, tile_idx_d;
    logic               out_last_q, out_last_d;
    logic [TW-1:0]      core_out;
    logic               accept, last_elem, out_hs, load;

`ifdef WINO_BTDB_SAT_EN
    logic core_sat;
    logic sat_hit_q, sat_hit_d;
`endif

    wino_btdb_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_core (
        .tile_in (bank_q[rd_ptr_q]),
        .tile_out(core_out)
`ifdef WINO_BTDB_SAT_EN
        ,
        .sat_hit (core_sat)
`endif
    );

    assign in_ready = ~full_q[wr_ptr_q];

    always_comb begin
        accept    = in_valid & ~full_q[wr_ptr_q];
        last_elem = (cnt_q == 4'd8);
        out_hs    = out_valid_q & out_ready;
        load      = full_q[rd_ptr_q] & (~out_valid_q | out_ready);

        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        bank_d   = bank_q;
        if (accept) begin
            bank_d[wr_ptr_q][cnt_q*DATA_WIDTH +: DATA_WIDTH] = in_data;
            cnt_d    = last_elem ? 4'd0 : cnt_q + 4'd1;
            wr_ptr_d = wr_ptr_q ^ last_elem;
        end

        rd_ptr_d = rd_ptr_q ^ load;

        // clear before set so a same-cycle drain and refill keeps the new tile
        full_d = full_q;
        if (load) begin
            full_d[rd_ptr_q] = 1'b0;
        end
        if (accept && last_elem) begin
            full_d[wr_ptr_q] = 1'b1;
        end

        out_valid_d = load | (out_valid_q & ~out_ready);
        out_data_d  = load ? core_out : out_data_q;

        tile_idx_d = tile_idx_q;
        if (out_hs) begin
            tile_idx_d = (tile_idx_q == LAST_IDX) ? '0 : tile_idx_q + 1'b1;
        end
        out_last_d = out_valid_d & (tile_idx_d == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            full_q      <= '0;
            bank_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            tile_idx_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            full_q      <= full_d;
            bank_q      <= bank_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            tile_idx_q  <= tile_idx_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef WINO_BTDB_SAT_EN
    assign sat_hit_d = load & core_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_hit_q <= 1'b0;
        end else begin
            sat_hit_q <= sat_hit_d;
        end
    end

    assign sat_hit = sat_hit_q;
`endif

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_tile_idx = tile_idx_q;
    assign out_last     = out_last_q;
    assign frame_done   = out_hs & out_last_q;

endmodule
